// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD seven-segment scan driver: segment width and
// glyph patterns in {g,f,e,d,c,b,a} order, active-high.
package bcd_disp_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder; non-BCD codes render
// as a dash so a corrupted counter digit is visible rather than misleading.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment scanner: per-frame snapshot of the BCD
// digits, anti-ghost blanking at each slot start and leading-zero blanking.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CNT_W = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] digits_snap_r;
    logic [NUM_DIGITS-1:0]   dp_snap_r;
    logic                    lzb_snap_r;
    logic [SEG_W-1:0]        seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_start_r;

    logic [CNT_W-1:0]        cnt_next_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic                    frame_edge_s;
    logic                    show_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    suppress_s;
    logic [SEG_W-1:0]        dec_seg_s;
    logic [NUM_DIGITS-1:0]   an_sel_s;

    // Slot counter and digit index advance
    always_comb begin
        cnt_next_s = cnt_r + CNT_W'(1);
        idx_next_s = idx_r;
        if (cnt_r == CNT_W'(PRESCALE - 1)) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
                idx_next_s = {IDX_W{1'b0}};
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_next_s = idx_r;
        end
        frame_edge_s = (idx_r == {IDX_W{1'b0}}) && (cnt_r == {CNT_W{1'b0}});
        show_s       = (cnt_r >= CNT_W'(BLANK_CYCLES));
        an_sel_s     = ~(NUM_DIGITS'(1) << idx_r);
    end

    // Current-slot digit select and leading-zero suppression; scanning from
    // the top digit down tracks whether everything at or above k is zero.
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        cur_nib_s  = 4'h0;
        cur_dp_s   = 1'b0;
        suppress_s = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (digits_snap_r[4*k +: 4] == 4'h0);
            if (IDX_W'(k) == idx_r) begin
                cur_nib_s  = digits_snap_r[4*k +: 4];
                cur_dp_s   = dp_snap_r[k];
                suppress_s = lzb_snap_r && (k != 0) && all_zero;
            end else begin
                cur_nib_s  = cur_nib_s;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nibble (cur_nib_s),
        .seg    (dec_seg_s)
    );

    // Counters and per-frame input snapshot
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r         <= {CNT_W{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            digits_snap_r <= {(4*NUM_DIGITS){1'b0}};
            dp_snap_r     <= {NUM_DIGITS{1'b0}};
            lzb_snap_r    <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            idx_r <= idx_next_s;
            if (frame_edge_s) begin
                digits_snap_r <= digits_in;
                dp_snap_r     <= dp_in;
                lzb_snap_r    <= lzb_en;
            end
        end
    end

    // Registered display outputs for the current (idx, cnt) position
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_r         <= {SEG_W{1'b0}};
            dp_r          <= 1'b0;
            an_r          <= {NUM_DIGITS{1'b1}};
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_edge_s;
            if (show_s && !suppress_s) begin
                an_r  <= an_sel_s;
                seg_r <= dec_seg_s;
                dp_r  <= cur_dp_s;
            end else begin
                an_r  <= {NUM_DIGITS{1'b1}};
                seg_r <= {SEG_W{1'b0}};
                dp_r  <= 1'b0;
            end
        end
    end

    assign seg         = seg_r;
    assign dp          = dp_r;
    assign an          = an_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a short scan (PRESCALE=4,
// BLANK_CYCLES=1): every cycle of each frame is compared to hand-derived glyphs.
module tb_bcd_display_scan;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lzb_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int checks_r;
    int errors_r;

    bcd_display_scan #(
        .NUM_DIGITS   (4),
        .PRESCALE     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lzb_en      (lzb_en),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // segs packs slot k glyph at [7k +: 7]; lit marks slots that must light.
    // The next clock edge is expected to start the frame. Stops after stop_at
    // cycles; at cycle chg_at (after sampling) digits_in is changed to chg_val.
    task automatic run_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] dps, input logic [3:0] lit,
                             input int stop_at, input int chg_at,
                             input logic [15:0] chg_val);
        for (int c = 0; c < stop_at; c++) begin
            int slot;
            int cc;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dp;
            slot = c / 4;
            cc   = c % 4;
            @(posedge clk);
            #1;
            if (cc >= 1 && lit[slot]) begin
                exp_an  = ~(4'b0001 << slot);
                exp_seg = segs[7*slot +: 7];
                exp_dp  = dps[slot];
            end else begin
                exp_an  = 4'b1111;
                exp_seg = 7'h00;
                exp_dp  = 1'b0;
            end
            check_val($sformatf("%s_an_c%0d", tag, c),  {28'h0, an},  {28'h0, exp_an});
            check_val($sformatf("%s_seg_c%0d", tag, c), {25'h0, seg}, {25'h0, exp_seg});
            check_val($sformatf("%s_dp_c%0d", tag, c),  {31'h0, dp},  {31'h0, exp_dp});
            check_val($sformatf("%s_fs_c%0d", tag, c),  {31'h0, frame_start},
                      {31'h0, (c == 0)});
            if (c == chg_at) begin
                digits_in = chg_val;
            end
        end
    endtask

    initial begin
        checks_r  = 0;
        errors_r  = 0;
        reset     = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        lzb_en    = 1'b0;

        for (int i = 0; i < 5; i++) begin
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            lzb_en    = 1'($urandom);
            @(posedge clk);
            #1;
            check_val("rst_an",  {28'h0, an},  32'hF);
            check_val("rst_seg", {25'h0, seg}, 32'h0);
            check_val("rst_dp",  {31'h0, dp},  32'h0);
            check_val("rst_fs",  {31'h0, frame_start}, 32'h0);
        end

        digits_in = 16'h1234;
        dp_in     = 4'b0100;
        lzb_en    = 1'b0;
        reset     = 1'b1;
        run_frame("f1234a", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b1111, 16, -1, 16'h0);
        run_frame("f1234b", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b1111, 16, -1, 16'h0);

        digits_in = 16'h0070;
        dp_in     = 4'b1000;
        lzb_en    = 1'b1;
        run_frame("f0070", {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000, 4'b0011, 16, -1, 16'h0);

        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        run_frame("f0000lzb", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 4'b0001, 16, -1, 16'h0);

        digits_in = 16'h00F9;
        run_frame("f00F9", {7'h00, 7'h00, 7'h40, 7'h6F}, 4'b0000, 4'b0011, 16, -1, 16'h0);

        digits_in = 16'hABC8;
        dp_in     = 4'b0001;
        run_frame("fABC8", {7'h40, 7'h40, 7'h40, 7'h7F}, 4'b0001, 4'b1111, 16, -1, 16'h0);

        digits_in = 16'h0000;
        dp_in     = 4'b1111;
        lzb_en    = 1'b0;
        run_frame("f0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 4'b1111, 16, -1, 16'h0);

        // digits change during slot 2 must not reach the display this frame
        digits_in = 16'h1234;
        dp_in     = 4'b0100;
        run_frame("fmid", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b1111, 16, 9, 16'h5678);
        run_frame("f5678", {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0100, 4'b1111, 16, -1, 16'h0);

        // reset asserted during slot 2, then a clean restart from slot 0
        digits_in = 16'h1234;
        run_frame("fpre", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b1111, 10, -1, 16'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_an",  {28'h0, an},  32'hF);
        check_val("midrst_seg", {25'h0, seg}, 32'h0);
        check_val("midrst_dp",  {31'h0, dp},  32'h0);
        check_val("midrst_fs",  {31'h0, frame_start}, 32'h0);
        reset = 1'b1;
        run_frame("fpost", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'b1111, 16, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed seven-segment driver for a bank of cascaded BCD up/down counter digits. Sits directly downstream of the BCD counter stage. Takes the packed 4-bit digit values, snapshots them once per scan frame, decodes each digit to segments, and drives one digit at a time. Includes anti-ghosting blanking, leading-zero suppression and a frame-start pulse for the bench and for upstream logic.

## Interface
- NUM_DIGITS, 4, number of BCD digits scanned (≥1)
- PRESCALE, 1000, clock cycles per digit slot (> BLANK_CYCLES)
- BLANK_CYCLES, 8, cycles at slot start with all anodes off (≥1)
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- digits_in  in  4*NUM_DIGITS  packed BCD; nibble k = digit k; digit 0 = least significant
- dp_in  in  NUM_DIGITS  decimal point per digit
- lzb_en  in  1  leading-zero blanking enable
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp  out  1  decimal point, active-high
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low when lit
- frame_start  out  1  one-cycle pulse at start of each frame

## Operation
- State: slot index idx (0..NUM_DIGITS-1), slot cycle counter cnt (0..PRESCALE-1), snapshot registers for digits, dp and lzb.
- cnt increments every cycle. At PRESCALE-1 it wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Frame start occurs when idx=0 and cnt=0:
  - Snapshot digits_in, dp_in and lzb_en.
  - Assert frame_start for exactly that cycle.
  - Input changes at any other time have no effect until the next frame.
- Blank phase, cnt < BLANK_CYCLES: an = all ones, seg = 0, dp = 0.
- Show phase, cnt ≥ BLANK_CYCLES: an[idx] = 0 and all other anode bits are 1. seg = decode(snapshot digit idx). dp = snapshot dp[idx].
- Decode (hex, per seg bit order):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Nibbles 10–15 are invalid and show dash 40.
- Leading-zero blanking (snapshot lzb = 1):
  - Digit k ≥ 1 is suppressed if snapshot nibbles k..NUM_DIGITS-1 are all 0000.
  - Suppressed digits keep an all ones for the whole slot; seg and dp are 0.
  - Digit 0 is never suppressed.
  - An invalid nibble counts as non-zero.
- Suppression does not shorten a slot. Frame length is fixed at NUM_DIGITS*PRESCALE cycles.

## Timing
- Reset (reset=0 at an edge) sets:
  - idx=0, cnt=0, snapshots=0.
  - an=all ones, seg=0, dp=0, frame_start=0.
- All outputs are registered. Outputs for (idx,cnt) appear one cycle after the counter holds that value. frame_start therefore appears in the first cycle after the edge that starts the frame.
- First frame: the first rising edge with reset=1 starts frame 0, so frame_start is high in the following cycle.
- Subsequent frame_start pulses are exactly NUM_DIGITS*PRESCALE cycles apart.
- Within a slot, an is all ones for BLANK_CYCLES cycles, then low on one bit for PRESCALE-BLANK_CYCLES cycles.
- Reset mid-frame: outputs return to reset values on the next cycle, and scanning restarts at digit 0 with a new frame. No partial slot is resumed.
- Latency from digits_in change to display: up to one full frame plus one cycle.
- Counter widths: $clog2(PRESCALE) and $clog2(NUM_DIGITS), minimum 1 bit.

## Structure
- Package bcd_disp_pkg:
  - segment glyph constants SEG_0..SEG_9 and SEG_DASH;
  - localparam for seg width (7).
- Sub-module bcd_to_seg7: combinational 4-bit → 7-bit decoder using the package constants. Instantiated once, fed by the snapshot nibble selected by idx.
- Top module holds the counters, snapshot, suppression logic and output registers.

## Test plan
- Reset held low for 5 cycles with random inputs → every cycle an=1111, seg=00, dp=0, frame_start=0. After release, frame_start pulses 1 cycle later.
- PRESCALE=4, BLANK_CYCLES=1, digits_in=16'h1234, lzb_en=0, dp_in=4'b0100:
  - frame_start period = 16 cycles;
  - slot 0: an=1111 for 1 cycle, then 1110 with seg=66 for 3 cycles;
  - slot 1 shows 4F; slot 2 shows 5B with dp=1; slot 3 shows 06.
- digits_in=16'h0070, lzb_en=1 → slots 3 and 2 keep an=1111 throughout; slot 1 shows 07; slot 0 shows 3F.
- digits_in=16'h0000, lzb_en=1 → only slot 0 lights, seg=3F.
- digits_in=16'h00F9, lzb_en=1 → slot 1 shows dash 40; slot 0 shows 6F; slots 3 and 2 are suppressed.
- Change digits_in mid-frame (during slot 2) → displayed values unchanged until the next frame_start.
- Assert reset during slot 2 → an=1111 next cycle, and the restart begins at slot 0.
